// File: rtl/id_stage_if.sv
// Signal bundle between the decode stage and its neighbours: fetch, hazard and
// writeback inputs in, PC-control and the registered ID/EX bundle out.
interface id_stage_if;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;
  logic        ex_wreg;
  logic [4:0]  ex_rd;
  logic        mem_wreg;
  logic [4:0]  mem_rd;
  logic        wb_wreg;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wpc;
  logic [31:0] nextpc;
  logic [31:0] branch_pc;
  logic        ctrl_branch;
  logic [31:0] id_pc4;
  logic [31:0] id_a;
  logic [31:0] id_b;
  logic [31:0] id_imm;
  logic [4:0]  id_rd;
  logic [4:0]  id_sa;
  logic [3:0]  id_aluc;
  logic        id_wreg;
  logic        id_m2reg;
  logic        id_wmem;
  logic        id_aluimm;
  logic        id_shift;
  logic        id_valid;

  modport master (
    output if_pc, if_pc4, if_inst, ex_wreg, ex_rd, mem_wreg, mem_rd,
           wb_wreg, wb_rd, wb_data,
    input  wpc, nextpc, branch_pc, ctrl_branch, id_pc4, id_a, id_b, id_imm,
           id_rd, id_sa, id_aluc, id_wreg, id_m2reg, id_wmem, id_aluimm,
           id_shift, id_valid
  );

  modport slave (
    input  if_pc, if_pc4, if_inst, ex_wreg, ex_rd, mem_wreg, mem_rd,
           wb_wreg, wb_rd, wb_data,
    output wpc, nextpc, branch_pc, ctrl_branch, id_pc4, id_a, id_b, id_imm,
           id_rd, id_sa, id_aluc, id_wreg, id_m2reg, id_wmem, id_aluimm,
           id_shift, id_valid
  );
endinterface

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, register file, main decode, stall generation
// and branch/jump resolution feeding a registered ID/EX bundle.
module id_stage (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);
  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000, OP_J   = 6'b000010, OP_BEQ = 6'b000100,
    OP_BNE   = 6'b000101, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
    OP_ORI   = 6'b001101, OP_LW  = 6'b100011, OP_SW  = 6'b101011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_NOR = 4'd4,
    ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_SRA = 4'd8
  } alu_op_e;

  typedef struct packed {
    logic [31:0] pc4, a, b, imm;
    logic [4:0]  rd, sa;
    logic [3:0]  aluc;
    logic        wreg, m2reg, wmem, aluimm, shift, valid;
  } idex_t;

  logic [31:0] d_pc4, d_inst;
  logic [31:0] regs [32];
  opcode_e     op;
  logic [4:0]  rs, rt, rd, sa;
  logic [5:0]  funct;
  logic [31:0] a, b, imm_ext;
  logic        valid, wreg, m2reg, wmem, aluimm, shift, zext;
  logic        use_rs, use_rt, is_beq, is_bne, is_j;
  alu_op_e     aluc;
  logic [4:0]  dest;
  logic        stall, ctrl_branch;
  logic [31:0] branch_pc;
  idex_t       idex, idex_next;
  logic        unused_if_pc;

  assign op    = opcode_e'(d_inst[31:26]);
  assign rs    = d_inst[25:21];
  assign rt    = d_inst[20:16];
  assign rd    = d_inst[15:11];
  assign sa    = d_inst[10:6];
  assign funct = d_inst[5:0];
  assign imm_ext = zext ? {16'h0000, d_inst[15:0]} : {{16{d_inst[15]}}, d_inst[15:0]};

  // The fetch PC itself is not needed here; only its successor is.
  assign unused_if_pc = ^bus.if_pc;

  // Register file with write-before-read bypass from WB.
  always_comb begin
    a = '0;
    b = '0;
    if (rs != '0) a = (bus.wb_wreg && bus.wb_rd == rs) ? bus.wb_data : regs[rs];
    if (rt != '0) b = (bus.wb_wreg && bus.wb_rd == rt) ? bus.wb_data : regs[rt];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (bus.wb_wreg && bus.wb_rd != '0) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  always_comb begin
    valid = 1'b0; wreg = 1'b0; m2reg = 1'b0; wmem = 1'b0; aluimm = 1'b0;
    shift = 1'b0; zext = 1'b0; use_rs = 1'b0; use_rt = 1'b0;
    is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0;
    aluc = ALU_ADD;
    dest = '0;
    if (d_inst != '0) begin
      case (op)
        OP_RTYPE: begin
          valid = 1'b1; wreg = 1'b1; use_rs = 1'b1; use_rt = 1'b1; dest = rd;
          case (funct)
            6'b100000: aluc = ALU_ADD;
            6'b100010: aluc = ALU_SUB;
            6'b100100: aluc = ALU_AND;
            6'b100101: aluc = ALU_OR;
            6'b100111: aluc = ALU_NOR;
            6'b101010: aluc = ALU_SLT;
            6'b000000: begin aluc = ALU_SLL; shift = 1'b1; end
            6'b000010: begin aluc = ALU_SRL; shift = 1'b1; end
            6'b000011: begin aluc = ALU_SRA; shift = 1'b1; end
            6'b000100: aluc = ALU_SLL;
            6'b000110: aluc = ALU_SRL;
            6'b000111: aluc = ALU_SRA;
            default: begin
              valid = 1'b0; wreg = 1'b0; use_rs = 1'b0; use_rt = 1'b0; dest = '0;
            end
          endcase
        end
        OP_ADDI: begin valid = 1'b1; wreg = 1'b1; aluimm = 1'b1; use_rs = 1'b1; dest = rt; end
        OP_ANDI: begin
          valid = 1'b1; wreg = 1'b1; aluimm = 1'b1; use_rs = 1'b1; dest = rt;
          zext = 1'b1; aluc = ALU_AND;
        end
        OP_ORI: begin
          valid = 1'b1; wreg = 1'b1; aluimm = 1'b1; use_rs = 1'b1; dest = rt;
          zext = 1'b1; aluc = ALU_OR;
        end
        OP_LW: begin
          valid = 1'b1; wreg = 1'b1; m2reg = 1'b1; aluimm = 1'b1; use_rs = 1'b1; dest = rt;
        end
        OP_SW:  begin valid = 1'b1; wmem = 1'b1; aluimm = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
        OP_BEQ: begin valid = 1'b1; is_beq = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
        OP_BNE: begin valid = 1'b1; is_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
        OP_J:   begin valid = 1'b1; is_j = 1'b1; end
        default: ;
      endcase
    end
  end

  assign stall =
    (use_rs && rs != '0 && ((bus.ex_wreg && bus.ex_rd == rs) || (bus.mem_wreg && bus.mem_rd == rs))) ||
    (use_rt && rt != '0 && ((bus.ex_wreg && bus.ex_rd == rt) || (bus.mem_wreg && bus.mem_rd == rt)));

  // A stalled branch waits for its operands, so it never redirects while stalled.
  always_comb begin
    ctrl_branch = 1'b0;
    branch_pc   = '0;
    if (!stall) begin
      if ((is_beq && a == b) || (is_bne && a != b)) begin
        ctrl_branch = 1'b1;
        branch_pc   = d_pc4 + {{16{d_inst[15]}}, d_inst[15:0]};
      end else if (is_j) begin
        ctrl_branch = 1'b1;
        branch_pc   = {d_pc4[31:26], d_inst[25:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_pc4  <= '0;
      d_inst <= '0;
    end else if (ctrl_branch) begin
      d_pc4  <= bus.if_pc4;
      d_inst <= '0;
    end else if (!stall) begin
      d_pc4  <= bus.if_pc4;
      d_inst <= bus.if_inst;
    end
  end

  always_comb begin
    idex_next = '0;
    if (!stall && valid && !(is_beq || is_bne || is_j)) begin
      idex_next.pc4    = d_pc4;
      idex_next.a      = a;
      idex_next.b      = b;
      idex_next.imm    = imm_ext;
      idex_next.rd     = dest;
      idex_next.sa     = shift ? sa : 5'd0;
      idex_next.aluc   = aluc;
      idex_next.wreg   = wreg && dest != '0;
      idex_next.m2reg  = m2reg;
      idex_next.wmem   = wmem;
      idex_next.aluimm = aluimm;
      idex_next.shift  = shift;
      idex_next.valid  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idex <= '0;
    else     idex <= idex_next;
  end

  assign bus.wpc         = ~stall;
  assign bus.nextpc      = bus.if_pc4;
  assign bus.branch_pc   = branch_pc;
  assign bus.ctrl_branch = ctrl_branch;
  assign bus.id_pc4      = idex.pc4;
  assign bus.id_a        = idex.a;
  assign bus.id_b        = idex.b;
  assign bus.id_imm      = idex.imm;
  assign bus.id_rd       = idex.rd;
  assign bus.id_sa       = idex.sa;
  assign bus.id_aluc     = idex.aluc;
  assign bus.id_wreg     = idex.wreg;
  assign bus.id_m2reg    = idex.m2reg;
  assign bus.id_wmem     = idex.wmem;
  assign bus.id_aluimm   = idex.aluimm;
  assign bus.id_shift    = idex.shift;
  assign bus.id_valid    = idex.valid;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: cycle-level reference model of the decode stage, directed
// cases with literal expectations, then randomized instruction/hazard traffic.
module tb_id_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_if bus();
  id_stage dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic valid, wreg, m2reg, wmem, aluimm, shift, use_rs, use_rt, beq, bne, jmp;
    logic [3:0]  aluc;
    logic [4:0]  rd, sa;
    logic [31:0] imm;
  } dec_t;

  typedef struct packed {
    logic [31:0] pc4, a, b, imm;
    logic [4:0]  rd, sa;
    logic [3:0]  aluc;
    logic        wreg, m2reg, wmem, aluimm, shift, valid;
  } idex_t;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_rf [32];
  logic [31:0] n_rf [32];
  logic [31:0] m_pc4, m_inst, n_pc4, n_inst, pc, n_pc;
  idex_t       e_idex, n_idex;
  logic        e_wpc, e_cb;
  logic [31:0] e_bpc, e_nextpc;
  bit          pc_load = 1'b0;
  logic [31:0] pc_load_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction semantics as a lookup: what each opcode/funct must produce.
  function automatic dec_t mdec(input logic [31:0] i);
    dec_t d;
    d = '0;
    if (i == 32'h0) return d;
    d.imm   = {{16{i[15]}}, i[15:0]};
    d.valid = 1'b1;
    case (i[31:26])
      6'h00: begin
        case (i[5:0])
          6'h20: d.aluc = 4'd0;
          6'h22: d.aluc = 4'd1;
          6'h24: d.aluc = 4'd2;
          6'h25: d.aluc = 4'd3;
          6'h27: d.aluc = 4'd4;
          6'h2A: d.aluc = 4'd5;
          6'h00: begin d.aluc = 4'd6; d.shift = 1'b1; end
          6'h02: begin d.aluc = 4'd7; d.shift = 1'b1; end
          6'h03: begin d.aluc = 4'd8; d.shift = 1'b1; end
          6'h04: d.aluc = 4'd6;
          6'h06: d.aluc = 4'd7;
          6'h07: d.aluc = 4'd8;
          default: return '0;
        endcase
        d.wreg = 1'b1; d.use_rs = 1'b1; d.use_rt = 1'b1; d.rd = i[15:11];
        if (d.shift) d.sa = i[10:6];
      end
      6'h08: begin d.wreg = 1'b1; d.aluimm = 1'b1; d.use_rs = 1'b1; d.rd = i[20:16]; end
      6'h0C: begin
        d.wreg = 1'b1; d.aluimm = 1'b1; d.use_rs = 1'b1; d.rd = i[20:16];
        d.aluc = 4'd2; d.imm = {16'h0, i[15:0]};
      end
      6'h0D: begin
        d.wreg = 1'b1; d.aluimm = 1'b1; d.use_rs = 1'b1; d.rd = i[20:16];
        d.aluc = 4'd3; d.imm = {16'h0, i[15:0]};
      end
      6'h23: begin d.wreg = 1'b1; d.m2reg = 1'b1; d.aluimm = 1'b1; d.use_rs = 1'b1; d.rd = i[20:16]; end
      6'h2B: begin d.wmem = 1'b1; d.aluimm = 1'b1; d.use_rs = 1'b1; d.use_rt = 1'b1; end
      6'h04: begin d.beq = 1'b1; d.use_rs = 1'b1; d.use_rt = 1'b1; end
      6'h05: begin d.bne = 1'b1; d.use_rs = 1'b1; d.use_rt = 1'b1; end
      6'h02: d.jmp = 1'b1;
      default: return '0;
    endcase
    if (d.rd == 5'd0) d.wreg = 1'b0;
    return d;
  endfunction

  function automatic logic [31:0] rreg(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (bus.wb_wreg && bus.wb_rd == r) return bus.wb_data;
    return m_rf[r];
  endfunction

  function automatic bit hz(input logic [4:0] r);
    return r != 5'd0 && ((bus.ex_wreg && bus.ex_rd == r) || (bus.mem_wreg && bus.mem_rd == r));
  endfunction

  // Expected outputs for the current cycle and expected state after the next edge.
  task automatic model_eval();
    dec_t d;
    logic [31:0] a, b;
    logic [4:0] rs, rt;
    bit stall, tk;
    d  = mdec(m_inst);
    rs = m_inst[25:21];
    rt = m_inst[20:16];
    a  = rreg(rs);
    b  = rreg(rt);
    stall = (d.use_rs && hz(rs)) || (d.use_rt && hz(rt));
    tk = 1'b0;
    e_bpc = 32'h0;
    if (!stall) begin
      if ((d.beq && a == b) || (d.bne && a != b)) begin
        tk = 1'b1; e_bpc = m_pc4 + {{16{m_inst[15]}}, m_inst[15:0]};
      end else if (d.jmp) begin
        tk = 1'b1; e_bpc = {m_pc4[31:26], m_inst[25:0]};
      end
    end
    e_cb = tk;
    e_wpc = !stall;
    e_nextpc = pc + 32'd1;
    for (int i = 0; i < 32; i++) n_rf[i] = rst ? 32'h0 : m_rf[i];
    if (!rst && bus.wb_wreg && bus.wb_rd != 5'd0) n_rf[bus.wb_rd] = bus.wb_data;
    if (rst) begin n_pc4 = 32'h0; n_inst = 32'h0; end
    else if (tk) begin n_pc4 = bus.if_pc4; n_inst = 32'h0; end
    else if (!stall) begin n_pc4 = bus.if_pc4; n_inst = bus.if_inst; end
    else begin n_pc4 = m_pc4; n_inst = m_inst; end
    n_pc = rst ? 32'h0 : tk ? e_bpc : stall ? pc : pc + 32'd1;
    n_idex = '0;
    if (!rst && !stall && d.valid && !(d.beq || d.bne || d.jmp)) begin
      n_idex.pc4 = m_pc4; n_idex.a = a; n_idex.b = b; n_idex.imm = d.imm;
      n_idex.rd = d.rd; n_idex.sa = d.sa; n_idex.aluc = d.aluc; n_idex.wreg = d.wreg;
      n_idex.m2reg = d.m2reg; n_idex.wmem = d.wmem; n_idex.aluimm = d.aluimm;
      n_idex.shift = d.shift; n_idex.valid = 1'b1;
    end
  endtask

  task automatic step(input bit r, input logic [31:0] inst,
                      input bit exw, input logic [4:0] exd, input bit mw, input logic [4:0] md,
                      input bit ww, input logic [4:0] wd, input logic [31:0] wdat);
    @(posedge clk);
    #1;
    m_rf = n_rf; m_pc4 = n_pc4; m_inst = n_inst; e_idex = n_idex; pc = n_pc;
    if (pc_load) begin pc = pc_load_val; pc_load = 1'b0; end
    rst = r;
    bus.if_pc = pc; bus.if_pc4 = pc + 32'd1; bus.if_inst = inst;
    bus.ex_wreg = exw; bus.ex_rd = exd; bus.mem_wreg = mw; bus.mem_rd = md;
    bus.wb_wreg = ww; bus.wb_rd = wd; bus.wb_data = wdat;
    model_eval();
  endtask

  task automatic nop_step(input logic [31:0] inst);
    step(1'b0, inst, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wpc", 32'(bus.wpc), 32'(e_wpc));
      chk("nextpc", bus.nextpc, e_nextpc);
      chk("ctrl_branch", 32'(bus.ctrl_branch), 32'(e_cb));
      chk("branch_pc", bus.branch_pc, e_bpc);
      chk("id_pc4", bus.id_pc4, e_idex.pc4);
      chk("id_a", bus.id_a, e_idex.a);
      chk("id_b", bus.id_b, e_idex.b);
      chk("id_imm", bus.id_imm, e_idex.imm);
      chk("id_rd", 32'(bus.id_rd), 32'(e_idex.rd));
      chk("id_sa", 32'(bus.id_sa), 32'(e_idex.sa));
      chk("id_aluc", 32'(bus.id_aluc), 32'(e_idex.aluc));
      chk("id_wreg", 32'(bus.id_wreg), 32'(e_idex.wreg));
      chk("id_m2reg", 32'(bus.id_m2reg), 32'(e_idex.m2reg));
      chk("id_wmem", 32'(bus.id_wmem), 32'(e_idex.wmem));
      chk("id_aluimm", 32'(bus.id_aluimm), 32'(e_idex.aluimm));
      chk("id_shift", 32'(bus.id_shift), 32'(e_idex.shift));
      chk("id_valid", 32'(bus.id_valid), 32'(e_idex.valid));
    end
  end

  logic [5:0] fns [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A,
                           6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};

  function automatic logic [31:0] gen_inst();
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    case ($urandom_range(0, 15))
      0: return 32'h0;
      1: return $urandom;
      2, 3, 4: return {6'h00, rs, rt, rd, 5'($urandom), fns[$urandom_range(0, 11)]};
      5: return {6'h08, rs, rt, imm};
      6: return {6'h0C, rs, rt, imm};
      7: return {6'h0D, rs, rt, imm};
      8: return {6'h23, rs, rt, imm};
      9: return {6'h2B, rs, rt, imm};
      10: return {6'h04, rs, rs, imm};
      11: return {6'h04, rs, rt, imm};
      12: return {6'h05, rs, rt, imm};
      13: return {6'h02, 26'($urandom)};
      14: return {6'h00, rs, rt, rd, 5'($urandom), 6'($urandom)};
      default: return {6'($urandom), 26'($urandom)};
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    bus.if_pc = 32'h0; bus.if_pc4 = 32'h1; bus.if_inst = 32'h0;
    bus.ex_wreg = 1'b0; bus.ex_rd = 5'd0; bus.mem_wreg = 1'b0; bus.mem_rd = 5'd0;
    bus.wb_wreg = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'h0;
    for (int i = 0; i < 32; i++) n_rf[i] = 32'h0;
    n_pc4 = 32'h0; n_inst = 32'h0; n_pc = 32'h0; n_idex = '0;

    step(1'b1, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    chk_en = 1'b1;

    nop_step(32'h0);
    @(negedge clk);
    chk("lit_rst_valid", 32'(bus.id_valid), 32'd0);
    chk("lit_rst_wpc", 32'(bus.wpc), 32'd1);
    chk("lit_rst_cb", 32'(bus.ctrl_branch), 32'd0);
    chk("lit_rst_a", bus.id_a, 32'h0);

    // addi r4,r3,-1 after WB writes r3=5
    step(1'b0, 32'h2064FFFF, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'd5);
    nop_step(32'h0);
    nop_step(32'h0);
    @(negedge clk);
    chk("lit_addi_a", bus.id_a, 32'd5);
    chk("lit_addi_imm", bus.id_imm, 32'hFFFFFFFF);
    chk("lit_addi_aluc", 32'(bus.id_aluc), 32'd0);
    chk("lit_addi_aluimm", 32'(bus.id_aluimm), 32'd1);
    chk("lit_addi_rd", 32'(bus.id_rd), 32'd4);
    chk("lit_addi_wreg", 32'(bus.id_wreg), 32'd1);

    // add r5,r4,r4 against EX then MEM hazards on r4
    nop_step(32'h00842820);
    step(1'b0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("lit_stall_ex_wpc", 32'(bus.wpc), 32'd0);
    step(1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("lit_stall_mem_wpc", 32'(bus.wpc), 32'd0);
    chk("lit_stall_bubble", 32'(bus.id_valid), 32'd0);
    nop_step(32'h0);
    @(negedge clk);
    chk("lit_stall_release", 32'(bus.wpc), 32'd1);
    nop_step(32'h0);
    @(negedge clk);
    chk("lit_add_valid", 32'(bus.id_valid), 32'd1);
    chk("lit_add_rd", 32'(bus.id_rd), 32'd5);

    // beq r1,r2,+3 with r1=r2=7 at d_pc4=0x10
    step(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 32'd7);
    pc_load = 1'b1; pc_load_val = 32'h0F;
    step(1'b0, 32'h10220003, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, 32'd7);
    nop_step(32'h20210001);
    @(negedge clk);
    chk("lit_beq_cb", 32'(bus.ctrl_branch), 32'd1);
    chk("lit_beq_pc", bus.branch_pc, 32'h13);
    nop_step(32'h0);
    @(negedge clk);
    chk("lit_beq_bubble", 32'(bus.id_valid), 32'd0);
    nop_step(32'h0);
    @(negedge clk);
    chk("lit_beq_squash", 32'(bus.id_valid), 32'd0);

    // j 0x20 at d_pc4=0x08, then bne with equal operands
    pc_load = 1'b1; pc_load_val = 32'h07;
    nop_step(32'h08000020);
    nop_step(32'h0);
    @(negedge clk);
    chk("lit_j_cb", 32'(bus.ctrl_branch), 32'd1);
    chk("lit_j_pc", bus.branch_pc, 32'h20);
    nop_step(32'h14220003);
    nop_step(32'h0);
    @(negedge clk);
    chk("lit_bne_cb", 32'(bus.ctrl_branch), 32'd0);
    chk("lit_bne_pc", bus.branch_pc, 32'h0);

    // sll r2,r1,4
    nop_step(32'h00011100);
    nop_step(32'h0);
    nop_step(32'h0);
    @(negedge clk);
    chk("lit_sll_shift", 32'(bus.id_shift), 32'd1);
    chk("lit_sll_sa", 32'(bus.id_sa), 32'd4);
    chk("lit_sll_aluc", 32'(bus.id_aluc), 32'd6);
    chk("lit_sll_b", bus.id_b, 32'd7);

    nop_step(32'hFC000000);
    nop_step(32'h0);
    nop_step(32'h0);
    @(negedge clk);
    chk("lit_unk_valid", 32'(bus.id_valid), 32'd0);

    // add r6,r0,r0 while WB tries to write r0
    step(1'b0, 32'h00003020, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hDEAD);
    step(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hBEEF);
    nop_step(32'h0);
    @(negedge clk);
    chk("lit_r0_a", bus.id_a, 32'h0);
    chk("lit_r0_b", bus.id_b, 32'h0);
    chk("lit_r0_rd", 32'(bus.id_rd), 32'd6);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] wd;
      wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
      step($urandom_range(0, 199) == 0, gen_inst(),
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 0, 5'($urandom_range(0, 7)), wd);
    end

    nop_step(32'h0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
